// File: rtl/gnn_sel_pkg.sv
// Shared types and helpers for the select-walk decoder.
//   state_t      : burst FSM states (IDLE waits for a command, RUN emits beats)
//   MAX_W        : widest select vector the helpers support (OUT_W <= MAX_W)
//   code2onehot  : code 0 -> no lane, code k in 1..out_w -> bit k-1, code > out_w -> no lane
//   next_code    : walk rule; k -> k+1, out_w wraps to 1; 0 and illegal codes stay put
package gnn_sel_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] code2onehot(input logic [7:0] code,
                                                   input logic [7:0] out_w);
    logic [MAX_W-1:0] r;
    r = '0;
    if (code != 8'd0 && code <= out_w) begin
      r = {{(MAX_W-1){1'b0}}, 1'b1} << (code - 8'd1);
    end
    return r;
  endfunction

  function automatic logic [7:0] next_code(input logic [7:0] code,
                                           input logic [7:0] out_w);
    logic [7:0] r;
    r = code;
    if (code == out_w) begin
      r = 8'd1;
    end else if (code != 8'd0 && code < out_w) begin
      r = code + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sel_code_dec.sv
// Purely combinational select-code to one-hot decoder.
// Ports:
//   code : CODE_W-bit select code (0 = no lane, k = lane k-1, > OUT_W = no lane)
//   sel  : OUT_W-bit one-hot (or all-zero) select
module sel_code_dec
  import gnn_sel_pkg::*;
#(
  parameter int OUT_W  = 8,
  parameter int CODE_W = $clog2(OUT_W + 1)
) (
  input  logic [CODE_W-1:0] code,
  output logic [OUT_W-1:0]  sel
);

  assign sel = OUT_W'(code2onehot(8'(code), 8'(OUT_W)));

endmodule

// File: rtl/sel_walk_decoder.sv
// Registered burst select decoder. A command {start code, length} produces
// cmd_len+1 beats of one-hot select that walk across OUT_W lanes with wrap,
// under a valid/ready output handshake. OUT_W must not exceed gnn_sel_pkg::MAX_W.
// Optional build macro SEL_WALK_ERR_EN adds a sticky illegal-code flag.
// Ports:
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_code              : start code (0 = bubble burst)
//   cmd_len               : beats minus one
//   out_valid/out_ready   : beat handshake
//   out_sel, out_last     : registered select and final-beat flag
//   err_illegal, err_clr  : (SEL_WALK_ERR_EN only) sticky illegal-code flag and its clear
module sel_walk_decoder
  import gnn_sel_pkg::*;
#(
  parameter int OUT_W  = 8,
  parameter int CODE_W = $clog2(OUT_W + 1),
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CODE_W-1:0] cmd_code,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_sel,
  output logic              out_last
`ifdef SEL_WALK_ERR_EN
  ,
  output logic              err_illegal,
  input  logic              err_clr
`endif
);

  localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(OUT_W);

  state_t             state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [OUT_W-1:0]   sel_q, sel_d;
  logic               cmd_accept;
  logic               beat_accept;

  // A new command may enter when idle, or on the very handshake that retires
  // the last beat, so back-to-back bursts run without a gap.
  assign beat_accept = valid_q & out_ready;
  assign cmd_ready   = (state_q == IDLE) | (beat_accept & last_q);
  assign cmd_accept  = cmd_valid & cmd_ready;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    count_d = count_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (cmd_accept) begin
      state_d = RUN;
      code_d  = cmd_code;
      count_d = cmd_len;
      valid_d = 1'b1;
      last_d  = (cmd_len == '0);
    end else if (beat_accept) begin
      if (last_q) begin
        state_d = IDLE;
        code_d  = '0;
        count_d = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        code_d  = CODE_W'(next_code(8'(code_q), 8'(OUT_W)));
        count_d = count_q - LEN_W'(1);
        last_d  = (count_q == LEN_W'(1));
      end
    end
  end

  // The select register is fed from the decoded next code, so out_sel is a
  // plain flop output and never follows cmd_* combinationally.
  sel_code_dec #(
    .OUT_W  (OUT_W),
    .CODE_W (CODE_W)
  ) u_dec (
    .code (code_d),
    .sel  (sel_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      count_q <= count_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sel   = sel_q;
  assign out_last  = last_q;

`ifdef SEL_WALK_ERR_EN
  logic err_q, err_d;

  // Sticky flag; a new illegal command wins over a coincident clear.
  always_comb begin
    err_d = err_q & ~err_clr;
    if (cmd_accept && (cmd_code > MAX_CODE)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_illegal = err_q;
`else
  logic unused_max_code;
  assign unused_max_code = ^MAX_CODE;
`endif

endmodule
